add_arb: RTL and testbench
==========================

ADD_ARB -- requirements
Module: add_arb

Interface
REQ-001 Parameter WIDTH, default 15, total operand and result bit width.
REQ-002 Parameter WIDTH1, default 7, LSB segment width.
REQ-003 Parameter WIDTH2, default 8, MSB segment width; WIDTH SHALL equal WIDTH1+WIDTH2.
REQ-004 Parameter NREQ, fixed 4, number of requesters.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, synchronous and active-low.
REQ-007 req_valid  input  4  per-requester operand valid; bit i belongs to requester i.
REQ-008 req_ready  output  4  per-requester accept; bit i high means requester i's operands are taken at this edge.
REQ-009 x_in  input  4*WIDTH  packed X operands; requester i occupies bits [i*WIDTH+WIDTH-1 : i*WIDTH].
REQ-010 y_in  input  4*WIDTH  packed Y operands; same packing as x_in.
REQ-011 sum_out  output  WIDTH  registered result, (X+Y) mod 2^WIDTH.
REQ-012 sum_id  output  2  index of the requester that owns sum_out.
REQ-013 sum_valid  output  1  sum_out and sum_id are valid.
REQ-014 sum_ready  input  1  consumer accepts the result at this edge when sum_valid is also high.
REQ-015 busy  output  1  high while any pipeline stage holds a valid operation.

Function
REQ-016 Datapath: three register stages sharing one split adder.
- S0: captures the granted X and Y, the requester id, and a valid bit.
- S1: registers the WIDTH1-bit LSB sum, the LSB carry-out, the WIDTH2-bit MSB sum (carry-in 0), the id and the valid bit.
- S2 (output): registers {MSB sum + LSB carry, LSB sum}, the id and the valid bit.
REQ-017 Pipeline advance: adv = !sum_valid || sum_ready; when adv=1, every stage loads from its predecessor (bubbles included); when adv=0, every stage holds.
REQ-018 Latency: operands accepted at edge N SHALL appear on sum_out with sum_valid=1 after edge N+2, provided adv=1 at edges N+1 and N+2; each stalled cycle adds one cycle.
REQ-019 Throughput: one accept per cycle when adv=1 and at least one req_valid bit is high.
REQ-020 Arbitration: round-robin with pointer lp (last granted, 2 bits).
- Search order: lp+1, lp+2, lp+3, lp (mod 4); the first requester with req_valid high is granted.
REQ-021 req_ready is combinational: req_ready[g]=adv for the granted index g, and all other bits are 0.
- At most one bit of req_ready is high in any cycle.
- All bits are 0 when no req_valid bit is high or adv=0.
REQ-022 lp updates to g only on an edge where req_ready[g] && req_valid[g]; otherwise lp holds.
REQ-023 Requesters SHALL keep req_valid and their operands stable until accepted; the block SHALL NOT depend on this for correctness of other requesters.
REQ-024 Arithmetic: the LSB carry SHALL propagate into the MSB segment exactly once; the final MSB carry-out is discarded (wrap-around modulo 2^WIDTH).
REQ-025 Output hold: while sum_valid=1 and sum_ready=0, sum_out and sum_id SHALL be stable.
REQ-026 Simultaneous events: when a result is consumed and a new request is accepted at the same edge, neither is lost or duplicated.
REQ-027 busy = valid(S0) | valid(S1) | sum_valid.

Reset
REQ-028 On any rising edge with rst_n=0:
- all stage valid bits are cleared;
- sum_valid=0, sum_out=0, sum_id=0, lp=3 (so requester 0 has first priority);
- busy=0.
REQ-029 While rst_n=0, req_ready SHALL be 0.
REQ-030 Reset asserted mid-operation discards all in-flight operations; no result for them SHALL ever appear.
REQ-031 Data registers other than the outputs need not be cleared.

Verification
REQ-032 Single request, sum_ready=1: requester 2 only, X=0x007F, Y=0x0001, accepted at edge N -> after edge N+2: sum_out=0x0080, sum_id=2, sum_valid=1 for one cycle (tests the LSB carry).
REQ-033 Wrap-around: X=0x7FFF, Y=0x0001 -> sum_out=0x0000; X=0x4000, Y=0x4000 -> sum_out=0x0000.
REQ-034 Fairness: all four req_valid held high continuously, sum_ready=1, starting just after reset -> grants 0,1,2,3,0,1,... and one result per cycle from the third cycle onward, with sum_id following the same order.
REQ-035 Backpressure: stream from requester 1, sum_ready=0 for 3 cycles -> req_ready=0, sum_out/sum_id frozen, no result lost or repeated; results resume in order once sum_ready=1.
REQ-036 Reset mid-flight: two operations in S0/S1, rst_n=0 for one edge -> sum_valid=0, busy=0 afterwards, no stale result ever emitted; the next grant goes to requester 0 when all requesters request.
REQ-037 Random: constrained-random req_valid, operands and sum_ready compared against a reference queue model -> every accepted operation produces exactly one correct (X+Y) mod 2^15 result with the matching sum_id, in acceptance order.

Source files
------------

// File: rtl/add_arb.sv
// add_arb -- four-requester round-robin arbiter in front of a three-stage
// pipelined adder. The adder is split into an LSB segment and an MSB segment.
//
// Ports
//   clk        : clock. All state changes on its rising edge.
//   rst_n      : synchronous reset, active low.
//   req_valid  : [NREQ]  per-requester operand valid.
//   req_ready  : [NREQ]  per-requester accept. It is combinational and
//                         one-hot or zero.
//   x_in, y_in : [NREQ*WIDTH]  packed operands. Requester i is at [i*WIDTH +: WIDTH].
//   sum_out    : [WIDTH] registered (X+Y) mod 2^WIDTH.
//   sum_id     : [2]     index of the requester that owns sum_out.
//   sum_valid  : sum_out and sum_id are valid.
//   sum_ready  : consumer accepts the result when sum_valid is high.
//   busy       : any pipeline stage holds a valid operation.
//
// Pipeline: S0 holds the operands, S1 holds the split partial sums, and
// S2 is the output register. All stages advance together on
// adv = !sum_valid || sum_ready. When adv is low, the whole pipe freezes.

// Per-requester grant lane. It decides whether this requester wins the
// round-robin search, and if so it places its operands on the shared
// AND-OR mux.
module add_arb_lane #(
    parameter int WIDTH = 15,
    parameter int NREQ  = 4,
    parameter int LANE  = 0
) (
    input  logic [1:0]       lp,     // last granted requester
    input  logic [NREQ-1:0]  rot,    // req_valid rotated so bit r = priority rank r
    input  logic             valid,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             win,
    output logic [WIDTH-1:0] x_sel,
    output logic [WIDTH-1:0] y_sel
);
    localparam logic [1:0] IDX = 2'(LANE);

    logic [1:0]      rank;
    logic [NREQ-1:0] higher;

    // Rank 0 is the requester right after lp. This lane wins only when
    // no requester with a lower rank is asking.
    assign rank   = IDX - lp - 2'd1;
    assign higher = (NREQ'(1) << rank) - NREQ'(1);
    assign win    = valid && ((rot & higher) == '0);
    assign x_sel  = win ? x : '0;
    assign y_sel  = win ? y : '0;
endmodule

module add_arb #(
    parameter int WIDTH  = 15,
    parameter int WIDTH1 = 7,
    parameter int WIDTH2 = 8,
    parameter int NREQ   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   x_in,
    input  logic [NREQ*WIDTH-1:0]   y_in,
    output logic [WIDTH-1:0]        sum_out,
    output logic [1:0]              sum_id,
    output logic                    sum_valid,
    input  logic                    sum_ready,
    output logic                    busy
);
    localparam int STAGES = 2;

    typedef struct packed {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic [1:0]       id;
    } s0_t;

    typedef struct packed {
        logic [WIDTH2-1:0] msb;    // MSB segment sum with carry-in 0
        logic              carry;  // LSB segment carry-out
        logic [WIDTH1-1:0] lsb;
        logic [1:0]        id;
    } s1_t;

    // vld_pipe[0] = S0, vld_pipe[1] = S1, vld_pipe[2] = output stage
    logic [STAGES:0]                vld_pipe;
    logic [1:0]                     lp;
    logic                           adv;
    logic                           accept;
    logic [1:0]                     gid;
    logic [NREQ-1:0]                rot;
    logic [NREQ-1:0]                win;
    logic [NREQ-1:0][WIDTH-1:0]     x_sel;
    logic [NREQ-1:0][WIDTH-1:0]     y_sel;
    logic [WIDTH-1:0]               x_g;
    logic [WIDTH-1:0]               y_g;
    logic [WIDTH1:0]                lsb_full;
    s0_t                            s0;
    s1_t                            s1;

    assign sum_valid = vld_pipe[STAGES];
    assign busy      = |vld_pipe;
    assign adv       = !sum_valid || sum_ready;

    // Rotate the requests so that rot[0] is the first candidate after lp.
    always_comb begin
        rot = '0;
        for (int r = 0; r < NREQ; r++)
            rot[r] = req_valid[lp + 2'(r) + 2'd1];
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        add_arb_lane #(
            .WIDTH (WIDTH),
            .NREQ  (NREQ),
            .LANE  (i)
        ) u_lane (
            .lp    (lp),
            .rot   (rot),
            .valid (req_valid[i]),
            .x     (x_in[i*WIDTH +: WIDTH]),
            .y     (y_in[i*WIDTH +: WIDTH]),
            .win   (win[i]),
            .x_sel (x_sel[i]),
            .y_sel (y_sel[i])
        );
    end

    // At most one lane wins, so OR-ing the gated operands acts as the mux.
    always_comb begin
        x_g = '0;
        y_g = '0;
        gid = '0;
        for (int i = 0; i < NREQ; i++) begin
            x_g = x_g | x_sel[i];
            y_g = y_g | y_sel[i];
            if (win[i])
                gid = 2'(i);
        end
    end

    // The grant is offered only when the pipe can move and the block is
    // out of reset.
    assign req_ready = (rst_n && adv) ? win : '0;
    assign accept    = |req_ready;

    // LSB segment add. It is one bit wider so that the carry-out is kept
    // for the output stage.
    assign lsb_full = {1'b0, s0.x[WIDTH1-1:0]} + {1'b0, s0.y[WIDTH1-1:0]};

    // Control and output registers. These are the only registers that
    // are cleared on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            sum_out  <= '0;
            sum_id   <= '0;
            lp       <= 2'd3;
        end else begin
            if (accept)
                lp <= gid;
            if (adv) begin
                vld_pipe <= {vld_pipe[STAGES-1:0], accept};
                // The LSB carry enters the MSB segment only here. The MSB
                // carry-out falls off the top, so the sum wraps.
                sum_out  <= {s1.msb + WIDTH2'(s1.carry), s1.lsb};
                sum_id   <= s1.id;
            end
        end
    end

    // Datapath stages. They move with the pipe, bubbles included, and
    // need no reset because the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (adv) begin
            s0.x     <= x_g;
            s0.y     <= y_g;
            s0.id    <= gid;
            s1.lsb   <= lsb_full[WIDTH1-1:0];
            s1.carry <= lsb_full[WIDTH1];
            s1.msb   <= s0.x[WIDTH-1:WIDTH1] + s0.y[WIDTH-1:WIDTH1];
            s1.id    <= s0.id;
        end
    end
endmodule

// File: tb/tb_add_arb.sv
module tb_add_arb;
    localparam int W = 15;
    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   x_in;
    logic [N*W-1:0]   y_in;
    logic [W-1:0]     sum_out;
    logic [1:0]       sum_id;
    logic             sum_valid;
    logic             sum_ready;
    logic             busy;

    logic [W-1:0]     xs [N];
    logic [W-1:0]     ys [N];

    always #5 clk = ~clk;

    add_arb #(.WIDTH(15), .WIDTH1(7), .WIDTH2(8), .NREQ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .sum_out   (sum_out),
        .sum_id    (sum_id),
        .sum_valid (sum_valid),
        .sum_ready (sum_ready),
        .busy      (busy)
    );

    always_comb begin
        x_in = '0;
        y_in = '0;
        for (int i = 0; i < N; i++) begin
            x_in[i*W +: W] = xs[i];
            y_in[i*W +: W] = ys[i];
        end
    end

    typedef struct {
        logic [W-1:0] sum;
        logic [1:0]   id;
    } exp_t;

    typedef struct {
        int           id;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] sum;
    } vec_t;

    exp_t         sbq [$];
    int           gq  [$];
    int           checks = 0;
    int           errors = 0;

    // Reference model state. The monitor updates it on the falling edge.
    logic [1:0]   tlp;
    logic [3:0]   took;
    logic [3:0]   exp_rdy;
    logic         hold_prev;
    logic [W-1:0] prev_out;
    logic [1:0]   prev_id;
    logic [1:0]   idx;
    logic [W-1:0] esum;
    exp_t         e;
    exp_t         pe;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, want);
        end
    endtask

    // Monitor. Inputs change just after the rising edge, so at the falling
    // edge they are stable and show what the next rising edge will do.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ready", {28'd0, req_ready}, 32'd0);
            sbq.delete();
            tlp       = 2'd3;
            took      = '0;
            hold_prev = 1'b0;
        end else begin
            exp_rdy = '0;
            if (!sum_valid || sum_ready) begin
                for (int k = 1; k <= 4; k++) begin
                    idx = tlp + 2'(k);
                    if (exp_rdy == '0 && req_valid[idx])
                        exp_rdy[idx] = 1'b1;
                end
            end
            chk("arb_ready", {28'd0, req_ready}, {28'd0, exp_rdy});
            took = req_ready & req_valid;
            for (int i = 0; i < N; i++) begin
                if (took[i]) begin
                    esum  = xs[i] + ys[i];
                    pe.sum = esum;
                    pe.id  = 2'(i);
                    sbq.push_back(pe);
                    tlp = 2'(i);
                    gq.push_back(i);
                end
            end
            if (hold_prev) begin
                chk("hold_valid", {31'd0, sum_valid}, 32'd1);
                chk("hold_sum", {17'd0, sum_out}, {17'd0, prev_out});
                chk("hold_id", {30'd0, sum_id}, {30'd0, prev_id});
            end
            hold_prev = sum_valid && !sum_ready;
            prev_out  = sum_out;
            prev_id   = sum_id;
            if (sum_valid && sum_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_extra got id %0d sum %0h want no result", sum_id, sum_out);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_sum", {17'd0, sum_out}, {17'd0, e.sum});
                    chk("sb_id", {30'd0, sum_id}, {30'd0, e.id});
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Give new operands to every requester whose request was just taken.
    task automatic refresh();
        for (int i = 0; i < N; i++)
            if (took[i]) begin
                xs[i] = W'($urandom);
                ys[i] = W'($urandom);
            end
    endtask

    task automatic drain();
        int n;
        n = 0;
        req_valid = '0;
        sum_ready = 1'b1;
        while ((busy || sbq.size() != 0) && n < 50) begin
            cyc();
            n++;
        end
        chk("drain_busy", {31'd0, busy}, 32'd0);
        chk("drain_sb", sbq.size(), 32'd0);
    endtask

    vec_t vt [8];

    initial begin
        vt[0] = '{2, 15'h007F, 15'h0001, 15'h0080};
        vt[1] = '{0, 15'h7FFF, 15'h0001, 15'h0000};
        vt[2] = '{1, 15'h4000, 15'h4000, 15'h0000};
        vt[3] = '{3, 15'h7FFF, 15'h7FFF, 15'h7FFE};
        vt[4] = '{0, 15'h0040, 15'h0040, 15'h0080};
        vt[5] = '{3, 15'h1234, 15'h0FFF, 15'h2233};
        vt[6] = '{1, 15'h5555, 15'h2AAB, 15'h0000};
        vt[7] = '{2, 15'h5555, 15'h2AAA, 15'h7FFF};

        rst_n     = 1'b0;
        req_valid = 4'hF;
        sum_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            xs[i] = '0;
            ys[i] = '0;
        end
        repeat (3) cyc();
        chk("rst_valid", {31'd0, sum_valid}, 32'd0);
        chk("rst_sum", {17'd0, sum_out}, 32'd0);
        chk("rst_id", {30'd0, sum_id}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        req_valid = '0;
        rst_n     = 1'b1;
        cyc();

        // Single requests through the table: check latency, carry and wrap.
        for (int v = 0; v < 8; v++) begin
            xs[vt[v].id] = vt[v].x;
            ys[vt[v].id] = vt[v].y;
            req_valid    = 4'(1 << vt[v].id);
            sum_ready    = 1'b1;
            cyc();
            req_valid = '0;
            cyc();
            cyc();
            chk("vec_valid", {31'd0, sum_valid}, 32'd1);
            chk("vec_sum", {17'd0, sum_out}, {17'd0, vt[v].sum});
            chk("vec_id", {30'd0, sum_id}, 32'(vt[v].id));
            cyc();
            chk("vec_pulse", {31'd0, sum_valid}, 32'd0);
        end

        // Fairness: everyone requests right after reset.
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        gq.delete();
        for (int i = 0; i < N; i++) begin
            xs[i] = W'($urandom);
            ys[i] = W'($urandom);
        end
        req_valid = 4'hF;
        sum_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            refresh();
            if (k >= 3)
                chk("fair_stream", {31'd0, sum_valid}, 32'd1);
        end
        drain();
        chk("fair_cnt", {31'd0, gq.size() >= 8}, 32'd1);
        for (int k = 0; k < 8; k++)
            chk("fair_order", gq[k], k % 4);

        // Backpressure on a stream from requester 1.
        req_valid = 4'b0010;
        sum_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            refresh();
        end
        sum_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            refresh();
            chk("bp_ready", {28'd0, req_ready}, 32'd0);
            chk("bp_valid", {31'd0, sum_valid}, 32'd1);
        end
        sum_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            refresh();
        end
        drain();

        // Reset while two operations sit in S0 and S1.
        req_valid = 4'hF;
        sum_ready = 1'b1;
        cyc();
        refresh();
        cyc();
        refresh();
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        cyc();
        chk("mid_valid", {31'd0, sum_valid}, 32'd0);
        chk("mid_idle", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("mid_grant0", {28'd0, req_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            cyc();
            refresh();
        end
        drain();

        // Random traffic checked by the scoreboard.
        req_valid = '0;
        for (int c = 0; c < 400; c++) begin
            cyc();
            for (int i = 0; i < N; i++) begin
                if (took[i])
                    req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    req_valid[i] = 1'b1;
                    xs[i] = W'($urandom);
                    ys[i] = W'($urandom);
                end
            end
            sum_ready = ($urandom_range(0, 3) != 0);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
